// File: rtl/mem_bus_ctrl_pkg.sv
// Shared state type, defaults and helpers for the memory bus controller.
// Define BUS_TIMEOUT_EN to let STROBE give up after TIMEOUT_CYCLES of ready low.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD
    } bus_state_e;

    localparam int MEM_WAIT_DEFAULT    = 1;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

`ifdef BUS_TIMEOUT_EN
    localparam bit BUS_TIMEOUT_ENABLED = 1'b1;
`else
    localparam bit BUS_TIMEOUT_ENABLED = 1'b0;
`endif

    // Cycle-count parameters below one would make the counters meaningless.
    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_wait_timer.sv
// Wait-state down-counter plus the optional ready-timeout counter.
// The timeout half only counts when BUS_TIMEOUT_EN is defined.
module bus_wait_timer
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES    = MEM_WAIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    input  logic ready,
    output logic expired,
    output logic timeout
);

    localparam logic [15:0] WAIT_LOAD    = 16'(at_least_one(WAIT_CYCLES) - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(at_least_one(TIMEOUT_CYCLES) - 1);

    logic [15:0] wait_count;
    logic [15:0] stuck_count;
    logic        stuck;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_count <= 16'd0;
        end else if (load) begin
            wait_count <= WAIT_LOAD;
        end else if (run && (wait_count != 16'd0)) begin
            wait_count <= wait_count - 16'd1;
        end
    end

    assign expired = (wait_count == 16'd0);

    // A cycle is "stuck" when the wait has elapsed but the device still is not ready.
    assign stuck = BUS_TIMEOUT_ENABLED && run && expired && !ready;

    always_ff @(posedge clk) begin
        if (rst || !stuck) begin
            stuck_count <= 16'd0;
        end else begin
            stuck_count <= stuck_count + 16'd1;
        end
    end

    assign timeout = stuck && (stuck_count == TIMEOUT_LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// SRAM-style bus controller: turns decoder rd/wr strobes into a setup/strobe/hold bus cycle.
// Build with BUS_TIMEOUT_EN defined to abort strobes whose ready never arrives.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES    = MEM_WAIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_bus_addr,
    output logic [15:0] o_bus_wdata,
    input  logic [15:0] i_bus_rdata,
    output logic        o_bus_cs,
    output logic        o_bus_oe,
    output logic        o_bus_we,
    input  logic        i_bus_ready
);

    bus_state_e state;
    bus_state_e next_state;
    logic       dir;
    logic       accept;
    logic       conflict;
    logic       expired;
    logic       timeout;
    logic       read_ok;
    logic       read_timeout;

    bus_wait_timer #(
        .WAIT_CYCLES   (WAIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (i_clk),
        .rst    (i_rst),
        .load   (state == BUS_SETUP),
        .run    (state == BUS_STROBE),
        .ready  (i_bus_ready),
        .expired(expired),
        .timeout(timeout)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        conflict   = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (i_mem_rd && i_mem_wr) begin
                    conflict = 1'b1;
                end else if (i_mem_rd || i_mem_wr) begin
                    accept     = 1'b1;
                    next_state = BUS_SETUP;
                end
            end
            BUS_SETUP:  next_state = BUS_STROBE;
            BUS_STROBE: begin
                if (expired && (i_bus_ready || timeout)) begin
                    next_state = BUS_HOLD;
                end
            end
            BUS_HOLD:   next_state = BUS_IDLE;
            default:    next_state = BUS_IDLE;
        endcase
    end

    // Stall drops in HOLD so the core advances on the same edge the bus cycle closes.
    assign o_stall = ((state == BUS_IDLE) && (i_mem_rd ^ i_mem_wr))
                   || (state == BUS_SETUP) || (state == BUS_STROBE);

    assign read_ok      = (state == BUS_STROBE) && expired && i_bus_ready && !dir;
    assign read_timeout = (state == BUS_STROBE) && timeout && !dir;

    // Bus strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= BUS_IDLE;
            dir         <= 1'b0;
            o_rdata     <= 16'h0000;
            o_bus_addr  <= 16'h0000;
            o_bus_wdata <= 16'h0000;
            o_bus_cs    <= 1'b0;
            o_bus_oe    <= 1'b0;
            o_bus_we    <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                dir         <= i_mem_wr;
                o_bus_addr  <= i_addr;
                o_bus_wdata <= i_wdata;
            end
            if (read_ok) begin
                o_rdata <= i_bus_rdata;
            end else if (read_timeout) begin
                o_rdata <= 16'hFFFF;
            end
            o_bus_cs <= (next_state != BUS_IDLE);
            o_bus_oe <= (next_state == BUS_STROBE) && !dir;
            o_bus_we <= (next_state == BUS_STROBE) && dir;
            o_done   <= (next_state == BUS_HOLD);
            o_err    <= conflict || ((state == BUS_STROBE) && timeout);
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: a W=1 and a W=3 instance, table-driven
// transactions checked through a scoreboard, plus conflict/reset/timeout sequences.
module tb_mem_bus_ctrl;

    typedef struct {
        bit          use_b;
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        bit          glitch;
        int          exp_stall;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          stall_n;
        int          cs_n;
        int          oe_n;
        int          we_n;
        int          err_n;
        int          done_at;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        idle_cs;
        logic        idle_done;
    } obs_t;

    logic        clk;
    logic        rst;
    bit          use_b;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] bus_rdata;
    logic        bus_ready;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [15:0] rdata_a, rdata_b, bus_addr_a, bus_addr_b, bus_wdata_a, bus_wdata_b;
    logic        stall_a, stall_b, done_a, done_b, err_a, err_b;
    logic        cs_a, cs_b, oe_a, oe_b, we_a, we_b;

    logic        sel_stall, sel_cs, sel_oe, sel_we, sel_done, sel_err;
    logic [15:0] sel_rdata, sel_bus_addr, sel_bus_wdata;

    int   n_checks;
    int   n_pass;
    vec_t vecs[8];
    obs_t sb[$];

    assign rd_a = req_rd & ~use_b;
    assign wr_a = req_wr & ~use_b;
    assign rd_b = req_rd & use_b;
    assign wr_b = req_wr & use_b;

    assign sel_stall     = use_b ? stall_b     : stall_a;
    assign sel_cs        = use_b ? cs_b        : cs_a;
    assign sel_oe        = use_b ? oe_b        : oe_a;
    assign sel_we        = use_b ? we_b        : we_a;
    assign sel_done      = use_b ? done_b      : done_a;
    assign sel_err       = use_b ? err_b       : err_a;
    assign sel_rdata     = use_b ? rdata_b     : rdata_a;
    assign sel_bus_addr  = use_b ? bus_addr_b  : bus_addr_a;
    assign sel_bus_wdata = use_b ? bus_wdata_b : bus_wdata_a;

    mem_bus_ctrl #(.WAIT_CYCLES(1), .TIMEOUT_CYCLES(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_mem_rd(rd_a), .i_mem_wr(wr_a),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_a), .o_stall(stall_a),
        .o_done(done_a), .o_err(err_a), .o_bus_addr(bus_addr_a),
        .o_bus_wdata(bus_wdata_a), .i_bus_rdata(bus_rdata), .o_bus_cs(cs_a),
        .o_bus_oe(oe_a), .o_bus_we(we_a), .i_bus_ready(bus_ready)
    );

    mem_bus_ctrl #(.WAIT_CYCLES(3), .TIMEOUT_CYCLES(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_mem_rd(rd_b), .i_mem_wr(wr_b),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_b), .o_stall(stall_b),
        .o_done(done_b), .o_err(err_b), .o_bus_addr(bus_addr_b),
        .o_bus_wdata(bus_wdata_b), .i_bus_rdata(bus_rdata), .o_bus_cs(cs_b),
        .o_bus_oe(oe_b), .o_bus_we(we_b), .i_bus_ready(bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pops the expectation pushed when the transaction was driven and compares it.
    task automatic checkOutput(input obs_t got, input string tag);
        obs_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        n_pass++;
        e = sb.pop_front();
        checkValue({tag, " stall_cycles"}, got.stall_n, e.stall_n);
        checkValue({tag, " cs_cycles"},    got.cs_n,    e.cs_n);
        checkValue({tag, " oe_cycles"},    got.oe_n,    e.oe_n);
        checkValue({tag, " we_cycles"},    got.we_n,    e.we_n);
        checkValue({tag, " err_cycles"},   got.err_n,   e.err_n);
        checkValue({tag, " done_latency"}, got.done_at, e.done_at);
        checkValue({tag, " rdata"},        got.rdata,   e.rdata);
        checkValue({tag, " bus_addr"},     got.addr,    e.addr);
        checkValue({tag, " bus_wdata"},    got.wdata,   e.wdata);
        checkValue({tag, " idle_cs"},      got.idle_cs,   e.idle_cs);
        checkValue({tag, " idle_done"},    got.idle_done, e.idle_done);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        obs_t e;
        obs_t got;
        int   w;
        w = v.use_b ? 3 : 1;
        got = '{default: 0};
        got.done_at = -1;
        @(negedge clk);
        use_b     = v.use_b;
        req_rd    = !v.is_wr;
        req_wr    = v.is_wr;
        addr      = v.addr;
        wdata     = v.wdata;
        bus_rdata = v.rdata;
        e.stall_n   = v.exp_stall;
        e.cs_n      = v.exp_stall;
        e.oe_n      = v.is_wr ? 0 : v.exp_stall - 2;
        e.we_n      = v.is_wr ? v.exp_stall - 2 : 0;
        e.err_n     = 0;
        e.done_at   = v.exp_stall;
        e.rdata     = v.exp_rdata;
        e.addr      = v.addr;
        e.wdata     = v.wdata;
        e.idle_cs   = 1'b0;
        e.idle_done = 1'b0;
        sb.push_back(e);
        for (int k = 0; k < 40 && got.done_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            bus_ready = (k >= w + 1 + v.delay) || (v.glitch && k >= 2 && k <= w);
            if (k == 1) begin
                addr  = ~v.addr;
                wdata = ~v.wdata;
            end
            #1;
            got.stall_n += int'(sel_stall);
            got.cs_n    += int'(sel_cs);
            got.oe_n    += int'(sel_oe);
            got.we_n    += int'(sel_we);
            got.err_n   += int'(sel_err);
            if (sel_done) got.done_at = k;
        end
        got.rdata = sel_rdata;
        got.addr  = sel_bus_addr;
        got.wdata = sel_bus_wdata;
        @(negedge clk);
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        bus_ready = 1'b0;
        #1;
        got.idle_cs   = sel_cs;
        got.idle_done = sel_done;
        checkOutput(got, tag);
    endtask

    initial begin
        vecs[0] = '{0, 0, 16'h1234, 16'h0000, 16'hBEEF, 0, 0, 3, 16'hBEEF};
        vecs[1] = '{1, 0, 16'h0010, 16'h0000, 16'h1357, 0, 0, 5, 16'h1357};
        vecs[2] = '{1, 1, 16'h00F0, 16'h5A5A, 16'hDEAD, 0, 0, 5, 16'h1357};
        vecs[3] = '{0, 0, 16'h2000, 16'h0000, 16'h2468, 4, 0, 7, 16'h2468};
        vecs[4] = '{0, 1, 16'h3000, 16'hA5A5, 16'h0BAD, 2, 0, 5, 16'h2468};
        vecs[5] = '{1, 0, 16'h4000, 16'h0000, 16'h0F0F, 1, 1, 6, 16'h0F0F};
        vecs[6] = '{0, 0, 16'hFFFE, 16'h0000, 16'h8001, 0, 0, 3, 16'h8001};
        vecs[7] = '{0, 0, 16'h5555, 16'h0000, 16'hC3C3, 0, 0, 3, 16'hC3C3};

        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        use_b     = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        addr      = 16'h0000;
        wdata     = 16'h0000;
        bus_rdata = 16'h0000;
        bus_ready = 1'b0;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        #1;
        checkValue("reset stall",     stall_a,     0);
        checkValue("reset cs",        cs_a,        0);
        checkValue("reset oe",        oe_a,        0);
        checkValue("reset we",        we_a,        0);
        checkValue("reset done",      done_a,      0);
        checkValue("reset err",       err_a,       0);
        checkValue("reset rdata",     rdata_a,     16'h0000);
        checkValue("reset bus_addr",  bus_addr_a,  16'h0000);
        checkValue("reset bus_wdata", bus_wdata_a, 16'h0000);
        checkValue("reset b cs",      cs_b,        0);
        checkValue("reset b rdata",   rdata_b,     16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // rd and wr together: error pulse, no bus cycle.
        @(negedge clk);
        use_b  = 1'b0;
        req_rd = 1'b1;
        req_wr = 1'b1;
        #1;
        checkValue("conflict stall", sel_stall, 0);
        @(negedge clk);
        req_rd = 1'b0;
        req_wr = 1'b0;
        #1;
        checkValue("conflict err pulse", sel_err, 1);
        checkValue("conflict no cs",     sel_cs,  0);
        @(negedge clk);
        #1;
        checkValue("conflict err clears", sel_err, 0);
        checkValue("conflict still no cs", sel_cs, 0);

        // Reset in the middle of a STROBE that is waiting on ready.
        @(negedge clk);
        req_rd    = 1'b1;
        addr      = 16'h7777;
        bus_rdata = 16'h9999;
        bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkValue("midreset oe in strobe", sel_oe, 1);
        @(negedge clk);
        rst    = 1'b1;
        req_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkValue("midreset cs",    sel_cs,    0);
        checkValue("midreset oe",    sel_oe,    0);
        checkValue("midreset we",    sel_we,    0);
        checkValue("midreset done",  sel_done,  0);
        checkValue("midreset stall", sel_stall, 0);
        checkValue("midreset rdata", sel_rdata, 16'h0000);
        @(negedge clk);
        #1;
        checkValue("midreset no late done", sel_done, 0);
        applyStimulus(vecs[7], "after_reset");

        // Ready tied low on a read.
        begin
            int stall_n;
            int done_at;
            logic err_at_done;
            logic [15:0] rdata_at_done;
            stall_n = 0;
            done_at = -1;
            err_at_done = 1'b0;
            rdata_at_done = 16'h0000;
            @(negedge clk);
            use_b     = 1'b0;
            req_rd    = 1'b1;
            addr      = 16'hABCD;
            bus_rdata = 16'h1111;
            bus_ready = 1'b0;
            for (int k = 0; k < 40 && done_at < 0; k++) begin
                if (k > 0) @(negedge clk);
                #1;
                stall_n += int'(sel_stall);
                if (sel_done) begin
                    done_at = k;
                    err_at_done = sel_err;
                    rdata_at_done = sel_rdata;
                end
            end
`ifdef BUS_TIMEOUT_EN
            checkValue("timeout done latency", done_at,       10);
            checkValue("timeout stall cycles", stall_n,       10);
            checkValue("timeout err",          err_at_done,   1);
            checkValue("timeout rdata",        rdata_at_done, 16'hFFFF);
`else
            checkValue("no-timeout done never", done_at, -1);
            checkValue("no-timeout stall held", stall_n, 40);
`endif
            @(negedge clk);
            req_rd = 1'b0;
            rst    = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkValue("final reset cs", sel_cs, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
